// File: rtl/uart_tx_arbiter.sv
// Purpose : round-robin, message-granular arbiter sharing one buffered UART transmitter
//           between N_REQ byte-stream requesters, with credit tracking of the transmitter FIFO.
// Latency : grant one edge after a request is seen in IDLE; a byte accepted at edge k
//           appears on Send_data/Data_TX for the cycle after edge k.
// Backpressure: Req_ready drops while no FIFO credits remain; each Tx_busy rise returns one credit.
//
// Ports:
//   Clk, Rst_n            clock, asynchronous active-low reset
//   Req_valid/Req_data/   per-requester byte stream (byte i in Req_data[8i+7:8i]),
//   Req_last/Req_ready    Req_last marks the final byte of a message
//   Grant                 one-hot owner of the transmitter, zero when idle
//   Tx_busy               transmitter busy flag; a rising edge means one FIFO entry was popped
//   Send_data/Data_TX     one-cycle push strobe and byte into the transmitter FIFO
//   Credits               free transmitter FIFO entries
//   Credit_err            sticky flag: a credit return arrived while already at full credit
module uart_tx_arbiter #(
   parameter int N_REQ   = 4,
   parameter int CREDITS = 15
) (
   input  logic               Clk,
   input  logic               Rst_n,
   input  logic [N_REQ-1:0]   Req_valid,
   input  logic [8*N_REQ-1:0] Req_data,
   input  logic [N_REQ-1:0]   Req_last,
   output logic [N_REQ-1:0]   Req_ready,
   output logic [N_REQ-1:0]   Grant,
   input  logic               Tx_busy,
   output logic               Send_data,
   output logic [7:0]         Data_TX,
   output logic [3:0]         Credits,
   output logic               Credit_err
);

   localparam int         IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [3:0] CRED_MAX = 4'(CREDITS);

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_t;

   // ---------------------------------------------------------------
   // State
   // ---------------------------------------------------------------
   state_t           state, state_nxt;
   logic [IDX_W-1:0] gnt_idx, gnt_idx_nxt;   // current owner while in STREAM
   logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;     // last requester that finished a message
   logic             send_q, send_nxt;
   logic [7:0]       data_q, data_nxt;
   logic [3:0]       cred_q, cred_nxt;
   logic             cred_err_q, cred_err_nxt;
   logic             busy_d;

   // ---------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------
   logic             pick_vld;
   logic [IDX_W-1:0] pick_idx;
   logic [IDX_W-1:0] cand_idx;
   logic [7:0]       sel_byte;
   logic             sel_vld;
   logic             sel_last;
   logic             have_cred;
   logic             hs;
   logic             ret;

   // Round-robin search: first valid requester starting just after rr_ptr,
   // wrapping modulo N_REQ. rr_ptr itself is examined last.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand_idx = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand_idx = IDX_W'((int'(rr_ptr) + k) % N_REQ);
         if (!pick_vld && Req_valid[cand_idx]) begin
            pick_vld = 1'b1;
            pick_idx = cand_idx;
         end
      end
   end

   // Select the owner's byte, valid and last flag.
   always_comb begin
      sel_byte = '0;
      sel_vld  = 1'b0;
      sel_last = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (IDX_W'(i) == gnt_idx) begin
            sel_byte = Req_data[8*i +: 8];
            sel_vld  = Req_valid[i];
            sel_last = Req_last[i];
         end
      end
   end

   // Grant is decoded from registered state only, so it drops to zero
   // the moment reset is asserted.
   always_comb begin
      Grant = '0;
      if (state == STREAM) begin
         Grant[gnt_idx] = 1'b1;
      end
   end

   // Ready depends only on registered state and credits: no path from Req_valid.
   assign have_cred = (cred_q != 4'd0);
   assign Req_ready = Grant & {N_REQ{have_cred}};

   assign hs  = (state == STREAM) && sel_vld && have_cred;
   // A busy rise means the transmitter pulled one byte out of its FIFO.
   assign ret = Tx_busy & ~busy_d;

   // ---------------------------------------------------------------
   // FSM next-state and push register inputs
   // ---------------------------------------------------------------
   always_comb begin
      state_nxt   = state;
      gnt_idx_nxt = gnt_idx;
      rr_ptr_nxt  = rr_ptr;
      send_nxt    = 1'b0;
      data_nxt    = data_q;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               gnt_idx_nxt = pick_idx;
               state_nxt   = STREAM;
            end
         end
         STREAM: begin
            // Grant is held through valid gaps until the last byte is accepted,
            // so bytes of different messages never interleave.
            if (hs) begin
               send_nxt = 1'b1;
               data_nxt = sel_byte;
               if (sel_last) begin
                  rr_ptr_nxt = gnt_idx;
                  state_nxt  = IDLE;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Credit counter: single update per cycle combining push and return
   // ---------------------------------------------------------------
   always_comb begin
      cred_nxt     = cred_q;
      cred_err_nxt = cred_err_q;
      case ({hs, ret})
         2'b10: cred_nxt = cred_q - 4'd1;
         2'b01: begin
            // A return at full credit means the transmitter popped more than
            // we pushed; hold the count and flag it until reset.
            if (cred_q == CRED_MAX) begin
               cred_err_nxt = 1'b1;
            end else begin
               cred_nxt = cred_q + 4'd1;
            end
         end
         default: cred_nxt = cred_q;
      endcase
   end

   // ---------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state      <= IDLE;
         gnt_idx    <= '0;
         rr_ptr     <= IDX_W'(N_REQ - 1);  // first grant goes to index 0
         send_q     <= 1'b0;
         data_q     <= 8'h00;
         cred_q     <= CRED_MAX;
         cred_err_q <= 1'b0;
         busy_d     <= 1'b1;               // no spurious return on reset release
      end else begin
         state      <= state_nxt;
         gnt_idx    <= gnt_idx_nxt;
         rr_ptr     <= rr_ptr_nxt;
         send_q     <= send_nxt;
         data_q     <= data_nxt;
         cred_q     <= cred_nxt;
         cred_err_q <= cred_err_nxt;
         busy_d     <= Tx_busy;
      end
   end

   assign Send_data  = send_q;
   assign Data_TX    = data_q;
   assign Credits    = cred_q;
   assign Credit_err = cred_err_q;

endmodule
